// File: rtl/dcache_store_responder.sv
// Memory-side responder for the store-buffer request port: grants single-beat writes into an
// in-order FIFO and drains it to a word-wide memory port. Optional macro DCACHE_STORE_RESP_COALESCE_EN.
module dcache_store_responder #(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned INDEX_W = 12,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic                      kill_i,
  input  logic [INDEX_W-1:0]        index_i,
  input  logic [PLEN-INDEX_W-1:0]   tag_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN/8-1:0]         be_i,
  input  logic [1:0]                size_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [XLEN-1:0]           rdata_o,
  output logic                      rd_err_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_ack_i,
  output logic [PLEN-1:0]           mem_addr_o,
  output logic [XLEN-1:0]           mem_wdata_o,
  output logic [XLEN/8-1:0]         mem_be_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned WA_W  = PLEN - OFF_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rvalid_q;
  logic               rd_err_q;

  // Entries keep only the word address; the byte offset is always zero on the memory side.
  logic [WA_W-1:0]    wa_mem   [DEPTH];
  logic [XLEN-1:0]    data_mem [DEPTH];
  logic [BE_W-1:0]    be_mem   [DEPTH];

  logic [PLEN-1:0]    req_addr;
  logic [WA_W-1:0]    req_wa;
  logic               coalesce_hit;
  logic               push;
  logic               pop;
  logic               has_head;
  logic               unused_bits;

  assign req_addr    = {tag_i, index_i};
  assign req_wa      = req_addr[PLEN-1:OFF_W];
  assign unused_bits = ^{size_i, req_addr[OFF_W-1:0]};

`ifdef DCACHE_STORE_RESP_COALESCE_EN
  logic [PTR_W-1:0] last_ptr;
  logic [XLEN-1:0]  merge_data;
  logic             merge;

  assign last_ptr = tail_q - PTR_W'(1);
  // The newest entry may absorb the write unless it is the head already handed to memory.
  assign coalesce_hit = we_i && (count_q != '0) && (wa_mem[last_ptr] == req_wa) &&
                        !((last_ptr == head_q) && (state_q != S_IDLE));
  assign merge = gnt_o && we_i && coalesce_hit;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
    assign merge_data[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : data_mem[last_ptr][gi*8 +: 8];
  end
`else
  assign coalesce_hit = 1'b0;
`endif

  assign gnt_o = req_i && !kill_i && (!we_i || (count_q != FULL_CNT) || coalesce_hit);
  assign push  = gnt_o && we_i && !coalesce_hit;
  assign pop   = (state_q == S_WAIT_ACK) && mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      wa_mem[tail_q]   <= req_wa;
      data_mem[tail_q] <= wdata_i;
      be_mem[tail_q]   <= be_i;
    end
`ifdef DCACHE_STORE_RESP_COALESCE_EN
    else if (merge) begin
      data_mem[last_ptr] <= merge_data;
      be_mem[last_ptr]   <= be_mem[last_ptr] | be_i;
    end
`endif
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (mem_ack_i) begin
          state_d = (count_d != '0) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rvalid_q <= gnt_o;
      rd_err_q <= gnt_o && !we_i;
    end
  end

  assign has_head    = (count_q != '0);
  assign mem_addr_o  = has_head ? {wa_mem[head_q], {OFF_W{1'b0}}} : '0;
  assign mem_wdata_o = has_head ? data_mem[head_q] : '0;
  assign mem_be_o    = has_head ? be_mem[head_q] : '0;

  assign rvalid_o = rvalid_q;
  assign rd_err_o = rd_err_q;
  assign rdata_o  = '0;
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_dcache_store_responder.sv
// Scoreboard bench for dcache_store_responder: a queue-based write model predicts grants,
// responses and drained memory writes; monitors compare whenever the DUT presents them.
module tb_dcache_store_responder;

  localparam int PLEN    = 56;
  localparam int XLEN    = 64;
  localparam int INDEX_W = 12;
  localparam int DEPTH   = 4;
  localparam int BE_W    = XLEN / 8;
`ifdef DCACHE_STORE_RESP_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    req_i, we_i, kill_i;
  logic [INDEX_W-1:0]      index_i;
  logic [PLEN-INDEX_W-1:0] tag_i;
  logic [XLEN-1:0]         wdata_i;
  logic [BE_W-1:0]         be_i;
  logic [1:0]              size_i;
  logic                    gnt_o, rvalid_o, rd_err_o, mem_req_o;
  logic [XLEN-1:0]         rdata_o;
  logic                    mem_gnt_i, mem_ack_i;
  logic [PLEN-1:0]         mem_addr_o;
  logic [XLEN-1:0]         mem_wdata_o;
  logic [BE_W-1:0]         mem_be_o;
  logic [$clog2(DEPTH):0]  count_o;
  logic                    empty_o;

  dcache_store_responder #(
    .PLEN(PLEN), .XLEN(XLEN), .INDEX_W(INDEX_W), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .kill_i(kill_i),
    .index_i(index_i), .tag_i(tag_i), .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rd_err_o(rd_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_ack_i(mem_ack_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [BE_W-1:0] be;
  } wr_t;

  // Reference state: pending writes in order, pending responses, and whether memory owns the head.
  wr_t exp_wr[$];
  bit  rsp_q[$];
  bit  busy    = 1'b0;
  bit  in_wait = 1'b0;
  int  cnt_start = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PLEN-1:0] word_of(input logic [PLEN-1:0] a);
    logic [PLEN-1:0] m;
    m = PLEN'(BE_W - 1);
    return a & ~m;
  endfunction

  function automatic bit model_hit(input logic [PLEN-1:0] a, input bit w);
    if (!COAL || !w || exp_wr.size() == 0) return 1'b0;
    if (exp_wr[exp_wr.size()-1].addr != word_of(a)) return 1'b0;
    if (exp_wr.size() == 1 && busy) return 1'b0;
    return 1'b1;
  endfunction

  // mm: 0 = memory stalls, 1 = random memory, 2 = memory grants and acks eagerly, 3 = grant only
  task automatic cycle(input bit rq, input bit w, input bit k, input logic [PLEN-1:0] a,
                       input logic [XLEN-1:0] d, input logic [BE_W-1:0] b, input int mm,
                       output bit granted);
    bit  hit, eg;
    wr_t e;
    @(negedge clk_i);
    cnt_start = exp_wr.size();
    req_i   = rq;
    we_i    = w;
    kill_i  = k;
    tag_i   = a[PLEN-1:INDEX_W];
    index_i = a[INDEX_W-1:0];
    wdata_i = d;
    be_i    = b;
    size_i  = 2'($urandom_range(0, 3));
    case (mm)
      0: begin mem_gnt_i = 1'b0; mem_ack_i = 1'b0; end
      1: begin
        mem_gnt_i = 1'($urandom_range(0, 1));
        mem_ack_i = in_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      end
      2: begin mem_gnt_i = 1'b1; mem_ack_i = 1'b1; end
      default: begin mem_gnt_i = 1'b1; mem_ack_i = 1'b0; end
    endcase
    #1;
    hit = model_hit(a, w);
    eg  = rq && !k && (!w || cnt_start < DEPTH || hit);
    check("gnt", gnt_o, eg);
    granted = eg;
    if (eg) begin
      rsp_q.push_back(!w);
      if (!w) begin
        $display("REQ read  addr=%0h", a);
      end else if (hit) begin
        e = exp_wr[exp_wr.size()-1];
        for (int i = 0; i < BE_W; i++)
          if (b[i]) e.data[i*8 +: 8] = d[i*8 +: 8];
        e.be = e.be | b;
        exp_wr[exp_wr.size()-1] = e;
        $display("REQ merge addr=%0h data=%0h be=%0h", a, d, b);
      end else begin
        e.addr = word_of(a);
        e.data = d;
        e.be   = b;
        exp_wr.push_back(e);
        $display("REQ write addr=%0h data=%0h be=%0h", a, d, b);
      end
    end
  endtask

  task automatic idle(input int mm);
    bit g;
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, mm, g);
  endtask

  task automatic wr(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                    input logic [BE_W-1:0] b, input int mm, output bit g);
    cycle(1'b1, 1'b1, 1'b0, a, d, b, mm, g);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || busy) && n < 100) begin
      idle(2);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; kill_i = 1'b0; mem_gnt_i = 1'b0; mem_ack_i = 1'b0;
    rst_ni = 1'b0;
    exp_wr.delete();
    rsp_q.delete();
    busy = 1'b0;
    in_wait = 1'b0;
    cnt_start = 0;
    #1;
    check("rst_count", count_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Response monitor: every grant must produce exactly one rvalid one cycle later.
  initial begin
    bit exp_v, e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_ni) begin
        exp_v = (rsp_q.size() != 0);
        check("rvalid", rvalid_o, exp_v);
        if (exp_v) begin
          e = rsp_q.pop_front();
          check("rd_err", rd_err_o, e);
          check("rdata", rdata_o, 0);
        end else begin
          check("rd_err_idle", rd_err_o, 0);
        end
      end
    end
  end

  // Memory monitor: occupancy, drain request, and in-order contents at each memory grant.
  initial begin
    wr_t h;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni) begin
        check("count", count_o, cnt_start);
        check("empty", empty_o, (cnt_start == 0) && !busy);
        check("mem_req", mem_req_o, busy && !in_wait);
        if (cnt_start == 0) begin
          check("mem_be_empty", mem_be_o, 0);
          check("mem_addr_empty", mem_addr_o, 0);
        end
        if (busy && !in_wait && mem_gnt_i) begin
          if (exp_wr.size() == 0) begin
            check("mem_grant_no_entry", 1, 0);
          end else begin
            h = exp_wr[0];
            check("mem_addr", mem_addr_o, h.addr);
            check("mem_wdata", mem_wdata_o, h.data);
            check("mem_be", mem_be_o, h.be);
            $display("MEM write addr=%0h data=%0h be=%0h", mem_addr_o, mem_wdata_o, mem_be_o);
          end
          in_wait = 1'b1;
        end else if (in_wait && mem_ack_i) begin
          if (exp_wr.size() != 0) void'(exp_wr.pop_front());
          in_wait = 1'b0;
          busy = (exp_wr.size() != 0);
        end else if (!busy) begin
          busy = (cnt_start != 0);
        end
      end
    end
  end

  initial begin
    bit g;
    int tries;
    logic [PLEN-1:0] a;
    logic [XLEN-1:0] d1, d2;
    int mode;

    rst_ni = 1'b1;
    req_i = 1'b0; we_i = 1'b0; kill_i = 1'b0; index_i = '0; tag_i = '0;
    wdata_i = '0; be_i = '0; size_i = '0; mem_gnt_i = 1'b0; mem_ack_i = 1'b0;
    #2 rst_ni = 1'b0;
    #5;
    check("rst_gnt", gnt_o, 0);
    check("rst_count0", count_o, 0);
    check("rst_empty0", empty_o, 1);
    check("rst_rvalid0", rvalid_o, 0);
    check("rst_rd_err0", rd_err_o, 0);
    check("rst_mem_req0", mem_req_o, 0);
    check("rst_mem_addr0", mem_addr_o, 0);
    check("rst_mem_wdata0", mem_wdata_o, 0);
    check("rst_mem_be0", mem_be_o, 0);
    check("rst_rdata0", rdata_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single write, then drain with an eager memory.
    wr(56'h1008, 64'hAABB, 8'h03, 0, g);
    idle(0);
    idle(0);
    check("single_mem_req", mem_req_o, 1);
    check("single_mem_addr", mem_addr_o, 56'h1008);
    check("single_mem_be", mem_be_o, 8'h03);
    drain();
    idle(0);
    check("single_empty", empty_o, 1);

    // Fill the FIFO with memory stalled; the fifth write waits for a pop to land.
    for (int i = 0; i < DEPTH; i++) wr(56'h3000 + 56'(i * 8), 64'(i + 1), 8'hFF, 0, g);
    wr(56'h3040, 64'h55, 8'hFF, 0, g);
    check("full_count", count_o, DEPTH);
    check("full_stall", gnt_o, 0);
    tries = 0;
    do begin
      wr(56'h3040, 64'h55, 8'hFF, 2, g);
      tries++;
    end while (!g && tries < 8);
    check("fifth_after_pop", tries, 3);
    drain();

    // Read and killed requests.
    cycle(1'b1, 1'b0, 1'b0, 56'h4000, '0, '0, 0, g);
    cycle(1'b1, 1'b1, 1'b1, 56'h4008, 64'h77, 8'hFF, 0, g);
    cycle(1'b1, 1'b0, 1'b1, 56'h4010, '0, '0, 0, g);
    idle(0);

    // Reset while memory owes an ack on a 3-entry FIFO.
    for (int i = 0; i < 3; i++) wr(56'h5000 + 56'(i * 8), 64'(i), 8'h0F, 0, g);
    idle(3);
    idle(3);
    check("pre_rst_count", count_o, 3);
    do_reset();
    repeat (5) idle(1);

    // Two half-word writes to one word while the drain is stalled.
    d1 = 64'h1111_2222_3333_4444;
    d2 = 64'h5555_6666_7777_8888;
    wr(56'h2000, d1, 8'h0F, 0, g);
    wr(56'h2004, d2, 8'hF0, 0, g);
    idle(0);
    check("coal_count", count_o, COAL ? 1 : 2);
    check("coal_be", mem_be_o, COAL ? 8'hFF : 8'h0F);
    check("coal_data", mem_wdata_o, COAL ? {d2[63:32], d1[31:0]} : d1);
    drain();

    // Randomized traffic over a small address pool so merges and full stalls occur.
    mode = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      a = 56'h10_0000 + 56'($urandom_range(0, 5) * 8) + 56'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = {$urandom(), $urandom()} & {PLEN{1'b1}};
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
            a, {$urandom(), $urandom()}, 8'($urandom()), mode, g);
    end
    drain();
    idle(0);
    check("final_empty", empty_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_store_responder.md
Name: dcache_store_responder

Overview:
- Responder (memory side) for the data-cache store-port handshake that the store buffer drives.
- Accepts single-beat write requests (req/gnt), acknowledges each grant with rvalid one cycle later, and queues writes in an in-order FIFO.
- Drains the FIFO to a simple word-wide memory port (req/gnt, then ack).
- Serves as a lightweight dcache stand-in for store-path bring-up and as the write front-end of a scratchpad.

Parameters:
PLEN, 56, physical address width
XLEN, 64, data width; 32 or 64
INDEX_W, 12, width of index_i; tag width = PLEN-INDEX_W
DEPTH, 4, write FIFO entries; power of two, >=2

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  1  request valid (data_req)
we_i  in  1  write enable; 0 = read
kill_i  in  1  kill request; suppresses grant this cycle
index_i  in  INDEX_W  address index (low address bits)
tag_i  in  PLEN-INDEX_W  address tag (high address bits)
wdata_i  in  XLEN  write data, already byte-aligned
be_i  in  XLEN/8  byte enables
size_i  in  2  transfer size; informational, not used for merging
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  response valid, one cycle after gnt_o
rdata_o  out  XLEN  response data; always 0
rd_err_o  out  1  pulses with rvalid_o when the granted request was a read
mem_req_o  out  1  memory write request
mem_gnt_i  in  1  memory accepted the request
mem_ack_i  in  1  memory write completed
mem_addr_o  out  PLEN  word-aligned address
mem_wdata_o  out  XLEN  head-entry data
mem_be_o  out  XLEN/8  head-entry byte enables
count_o  out  $clog2(DEPTH)+1  FIFO occupancy
empty_o  out  1  count_o==0 and drain FSM in IDLE

Behaviour:
- Reset: FIFO empty, count_o=0, drain FSM=IDLE, empty_o=1. gnt_o, rvalid_o, rd_err_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o and rdata_o are all 0. Reset mid-drain discards all entries; mem_req_o drops immediately.
- Grant (combinational): gnt_o = req_i & !kill_i & (!we_i | count_o<DEPTH | coalesce_hit).
- Full FIFO: a write is stalled (gnt_o=0) even if a pop completes in the same cycle. There is no pass-through when full.
- Address formation: addr = {tag_i, index_i}. Entry address = addr with the low log2(XLEN/8) bits cleared.
- Write grant: pushes {addr, wdata_i, be_i} at the tail. count_o increments next cycle unless a pop happens the same cycle, in which case count_o is unchanged.
- Read grant: nothing is pushed. Next cycle rvalid_o=1, rd_err_o=1, rdata_o=0.
- rvalid_o: registered copy of gnt_o, exactly 1 cycle later; one rvalid_o per grant. Back-to-back grants give back-to-back rvalid_o.
- Drain FSM (head entry drives mem_addr_o, mem_wdata_o, mem_be_o whenever count_o>0):
  - IDLE: if count_o>0, go to REQ.
  - REQ: mem_req_o=1, held until mem_gnt_i; then go to WAIT_ACK. Head entry is frozen.
  - WAIT_ACK: mem_req_o=0. mem_ack_i is only sampled in this state. On mem_ack_i, pop the head; go to REQ if post-pop count>0, else IDLE.
- Ack timing: an ack can arrive no earlier than the cycle after the grant, so the minimum memory turnaround is REQ→WAIT_ACK→(ack) = 2 cycles per entry.
- Ordering: strictly FIFO. Pointers wrap modulo DEPTH; a separate count register distinguishes full from empty.
- Simultaneous push and pop on the same entry is impossible: push targets the tail, pop targets the head, and the FIFO is never both empty and popping.

Optional Feature:
Macro DCACHE_STORE_RESP_COALESCE_EN.
- Defined:
  - coalesce_hit = we_i & count_o>0 & (tail-1 entry word address == incoming word address) & !(tail-1 is the head and FSM!=IDLE).
  - On a hit, bytes selected by be_i overwrite the entry's data; entry be |= be_i; count_o is unchanged. This is granted even when the FIFO is full.
  - Same-cycle pop of another entry is still legal.
- Undefined: coalesce_hit=0 and every write occupies its own entry.

Test Plan:
- Reset, then single write addr 0x1008 data 0xAABB be 0x03 (XLEN=64) → gnt_o same cycle, rvalid_o next cycle. mem_req_o rises 2 cycles after the grant with mem_addr_o=0x1008, mem_be_o=0x03. Ack → count_o=0, empty_o=1.
- 5 back-to-back writes, DEPTH=4, mem_gnt_i held 0 → 4 grants, 5th stalled (gnt_o=0, count_o=4). Single gnt+ack does not grant the 5th in the ack cycle; it is granted the next cycle.
- Read request (we_i=0) → gnt_o=1, next cycle rvalid_o=1, rd_err_o=1, rdata_o=0, count_o unchanged.
- kill_i=1 with req_i=1 → gnt_o=0, no push, no rvalid_o.
- Assert rst_ni=0 while in WAIT_ACK with 3 entries → mem_req_o=0 and count_o=0 immediately; no further mem_req_o after reset release.
- With COALESCE_EN: writes to 0x2000 be 0x0F then 0x2004 be 0xF0 while draining is stalled → count_o=1, drained mem_be_o=0xFF with merged data. Without the macro → count_o=2.
